count_sequence_monitor: RTL and testbench

//  Downstream consumer of the 3-bit ripple down counter. Takes the counter's Q0..Q2 (Q0 = LSB), which are asynchronous to CLK.

---
 rtl/count_mon_pkg.sv | 17 +
 rtl/count_sync_filter.sv | 66 ++++++
 rtl/count_sequence_monitor.sv | 97 +++++++++
 tb/tb_count_sequence_monitor.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the ripple-counter sequence monitor.
// No state; constants and a mod-8 decrement used by the checker FSM.
package count_mon_pkg;

    localparam int COUNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERROR = 2'd2
    } mon_state_t;

    function automatic logic [COUNT_W-1:0] dec_mod8(input logic [COUNT_W-1:0] v);
        return v - COUNT_W'(1);
    endfunction

endpackage

// File: rtl/count_sync_filter.sv
// Synchronises the async counter bits and accepts a value once it has been held STABLE_CYCLES samples.
// Latency: accept asserts SYNC_STAGES+STABLE_CYCLES-1 edges after first sampling edge; no backpressure (free-running).
module count_sync_filter
    import count_mon_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic               CLK,
    input  logic               not_RST,
    input  logic [COUNT_W-1:0] raw,
    output logic [COUNT_W-1:0] val,
    output logic               accept
);

    localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  RUN_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  RUN_ONE = CNT_W'(1);

    logic [COUNT_W-1:0]     sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q;
    logic [COUNT_W-1:0]     held_q;
    logic [CNT_W-1:0]       run_q;
    logic [CNT_W-1:0]       run_nxt;
    logic                   sample_vld;
    logic                   same;

    // fill_q marks which chain stages hold real samples rather than reset zeros,
    // so the cleared chain contents are never mistaken for a counter value.
    assign sample_vld = fill_q[SYNC_STAGES-1];
    assign same       = (run_q != '0) && (sync_q[SYNC_STAGES-1] == held_q);
    assign val        = sync_q[SYNC_STAGES-1];

    always_comb begin
        run_nxt = '0;
        if (sample_vld) begin
            if (!same)
                run_nxt = RUN_ONE;
            else if (run_q == RUN_MAX)
                run_nxt = RUN_MAX;
            else
                run_nxt = run_q + RUN_ONE;
        end
    end

    // Fires once per stable run: a run already saturated at RUN_MAX does not re-accept.
    assign accept = sample_vld && (run_nxt == RUN_MAX) && !(same && (run_q == RUN_MAX));

    always_ff @(posedge CLK) begin
        if (!not_RST) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            fill_q <= '0;
            held_q <= '0;
            run_q  <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            held_q <= sync_q[SYNC_STAGES-1];
            run_q  <= run_nxt;
        end
    end

endmodule

// File: rtl/count_sequence_monitor.sv
// Checks that filtered ripple-counter values step down by one (mod 8); reports count, step/wrap pulses, wrap tally, sticky error.
// Latency: COUNT follows a clean input SYNC_STAGES+STABLE_CYCLES edges after first sampling; no backpressure.
module count_sequence_monitor
    import count_mon_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int WRAP_W        = 8
) (
    input  logic               CLK,
    input  logic               not_RST,
    input  logic               CLR,
    input  logic               Q0,
    input  logic               Q1,
    input  logic               Q2,
    output logic [COUNT_W-1:0] COUNT,
    output logic               VALID,
    output logic               STEP,
    output logic               WRAP,
    output logic               ZERO,
    output logic [WRAP_W-1:0]  WRAPS,
    output logic               ERR
);

    mon_state_t         state;
    logic [COUNT_W-1:0] acc_val;
    logic               acc_vld;

    count_sync_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_filter (
        .CLK     (CLK),
        .not_RST (not_RST),
        .raw     ({Q2, Q1, Q0}),
        .val     (acc_val),
        .accept  (acc_vld)
    );

    assign ZERO = VALID && (COUNT == '0);

    always_ff @(posedge CLK) begin
        if (!not_RST) begin
            state <= IDLE;
            COUNT <= '0;
            VALID <= 1'b0;
            STEP  <= 1'b0;
            WRAP  <= 1'b0;
            WRAPS <= '0;
            ERR   <= 1'b0;
        end else if (CLR) begin
            // COUNT and the filter are left alone; an acceptance on this edge is dropped.
            state <= IDLE;
            VALID <= 1'b0;
            STEP  <= 1'b0;
            WRAP  <= 1'b0;
            WRAPS <= '0;
            ERR   <= 1'b0;
        end else begin
            STEP <= 1'b0;
            WRAP <= 1'b0;
            if (acc_vld) begin
                case (state)
                    IDLE: begin
                        COUNT <= acc_val;
                        VALID <= 1'b1;
                        state <= TRACK;
                    end
                    TRACK: begin
                        if (acc_val == COUNT) begin
                            state <= TRACK;
                        end else if (acc_val == dec_mod8(COUNT)) begin
                            COUNT <= acc_val;
                            STEP  <= 1'b1;
                            if (COUNT == '0) begin
                                WRAP <= 1'b1;
                                if (WRAPS != '1)
                                    WRAPS <= WRAPS + WRAP_W'(1);
                            end
                        end else begin
                            COUNT <= acc_val;
                            ERR   <= 1'b1;
                            state <= ERROR;
                        end
                    end
                    ERROR: begin
                        COUNT <= acc_val;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_sequence_monitor.sv
// Self-checking bench: table-driven counter sequences with a scoreboard queue plus hand-written reset/CLR/glitch corners.
module tb_count_sequence_monitor;

    logic       CLK = 1'b0;
    logic       not_RST;
    logic       CLR;
    logic       Q0, Q1, Q2;
    logic [2:0] COUNT;
    logic       VALID, STEP, WRAP, ZERO, ERR;
    logic [7:0] WRAPS;

    always #5 CLK = ~CLK;

    count_sequence_monitor #(
        .SYNC_STAGES   (2),
        .STABLE_CYCLES (2),
        .WRAP_W        (8)
    ) dut (
        .CLK     (CLK),
        .not_RST (not_RST),
        .CLR     (CLR),
        .Q0      (Q0),
        .Q1      (Q1),
        .Q2      (Q2),
        .COUNT   (COUNT),
        .VALID   (VALID),
        .STEP    (STEP),
        .WRAP    (WRAP),
        .ZERO    (ZERO),
        .WRAPS   (WRAPS),
        .ERR     (ERR)
    );

    typedef struct {
        logic [2:0] val;
        logic [2:0] cnt;
        logic       vld;
        logic       step;
        logic       wrap;
        logic       zero;
        logic       err;
        logic [7:0] wraps;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_seen = 0;
    int   wrap_seen = 0;
    int   bad_wrap  = 0;
    vec_t exp_q[$];
    vec_t t2[10];
    vec_t t4[7];

    always @(negedge CLK) begin
        if (not_RST === 1'b1) begin
            if (STEP === 1'b1) step_seen++;
            if (WRAP === 1'b1) wrap_seen++;
            if (WRAP === 1'b1 && STEP !== 1'b1) bad_wrap++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_raw(input logic [2:0] v);
        {Q2, Q1, Q0} = v;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, 32'(COUNT), 32'd0);
        check({tag, "_valid"}, 32'(VALID), 32'd0);
        check({tag, "_step"},  32'(STEP),  32'd0);
        check({tag, "_wrap"},  32'(WRAP),  32'd0);
        check({tag, "_zero"},  32'(ZERO),  32'd0);
        check({tag, "_wraps"}, 32'(WRAPS), 32'd0);
        check({tag, "_err"},   32'(ERR),   32'd0);
    endtask

    // Drive a value, expect the DUT response after the 4-edge filter latency, then a clean pulse end.
    task automatic drive_check(input vec_t v);
        vec_t e;
        set_raw(v.val);
        exp_q.push_back(v);
        repeat (4) tick();
        e = exp_q.pop_front();
        check($sformatf("count_v%0d", e.val), 32'(COUNT), 32'(e.cnt));
        check($sformatf("valid_v%0d", e.val), 32'(VALID), 32'(e.vld));
        check($sformatf("step_v%0d",  e.val), 32'(STEP),  32'(e.step));
        check($sformatf("wrap_v%0d",  e.val), 32'(WRAP),  32'(e.wrap));
        check($sformatf("zero_v%0d",  e.val), 32'(ZERO),  32'(e.zero));
        check($sformatf("err_v%0d",   e.val), 32'(ERR),   32'(e.err));
        check($sformatf("wraps_v%0d", e.val), 32'(WRAPS), 32'(e.wraps));
        tick();
        check($sformatf("step_end_v%0d", e.val), 32'(STEP), 32'd0);
        check($sformatf("wrap_end_v%0d", e.val), 32'(WRAP), 32'd0);
        tick();
    endtask

    initial begin
        int s0;
        int w0;
        int wr;
        logic [2:0] v;

        //            val cnt vld stp wrp zro err wraps
        t2[0] = '{3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        t2[1] = '{3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        t2[2] = '{3'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        t2[3] = '{3'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        t2[4] = '{3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        t2[5] = '{3'd7, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
        t2[6] = '{3'd6, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        t2[7] = '{3'd5, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        t2[8] = '{3'd4, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        t2[9] = '{3'd3, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};

        t4[0] = '{3'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
        t4[1] = '{3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd1};
        t4[2] = '{3'd7, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
        t4[3] = '{3'd6, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
        t4[4] = '{3'd3, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
        t4[5] = '{3'd2, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
        t4[6] = '{3'd1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};

        // Reset with 101 already on the inputs; first value must land exactly 4 edges after release.
        not_RST = 1'b0;
        CLR     = 1'b0;
        set_raw(3'b101);
        repeat (3) tick();
        check_reset_outputs("reset");
        not_RST = 1'b1;
        repeat (3) tick();
        check("first_early_valid", 32'(VALID), 32'd0);
        tick();
        check("first_count", 32'(COUNT), 32'd5);
        check("first_valid", 32'(VALID), 32'd1);
        check("first_step",  32'(STEP),  32'd0);
        check("first_err",   32'(ERR),   32'd0);
        repeat (2) tick();

        // Legal down-count including a 000 -> 111 wrap.
        for (int i = 0; i < 10; i++)
            drive_check(t2[i]);

        // One-cycle ripple intermediate between 011 and 010 must be ignored.
        s0 = step_seen;
        set_raw(3'b000);
        tick();
        drive_check('{3'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
        check("glitch_step_count", 32'(step_seen - s0), 32'd1);

        // Down to 110, then illegal jump to 011; later legal steps stay silent.
        for (int i = 0; i < 7; i++)
            drive_check(t4[i]);

        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check("clr_err",   32'(ERR),   32'd0);
        check("clr_valid", 32'(VALID), 32'd0);
        check("clr_wraps", 32'(WRAPS), 32'd0);
        check("clr_count", 32'(COUNT), 32'd1);
        check("clr_step",  32'(STEP),  32'd0);
        check("clr_zero",  32'(ZERO),  32'd0);

        // Acceptance on the same edge as CLR is dropped.
        set_raw(3'b000);
        repeat (3) tick();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check("clr_drop_valid", 32'(VALID), 32'd0);
        check("clr_drop_count", 32'(COUNT), 32'd1);
        check("clr_drop_step",  32'(STEP),  32'd0);
        repeat (3) tick();
        check("clr_drop_no_reaccept", 32'(VALID), 32'd0);

        // Next acceptance is IDLE-first: no STEP even though 000 -> 111 would be legal.
        drive_check('{3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});

        // 300 full down-cycles; tally saturates at 255.
        s0 = step_seen;
        w0 = wrap_seen;
        wr = 0;
        for (int c = 0; c < 300; c++) begin
            for (int k = 1; k <= 8; k++) begin
                v = 3'(7 - k);
                if (v == 3'd7 && wr < 255)
                    wr++;
                drive_check('{v, v, 1'b1, 1'b1, (v == 3'd7), (v == 3'd0), 1'b0, 8'(wr)});
            end
        end
        check("sat_steps", 32'(step_seen - s0), 32'd2400);
        check("sat_wraps_pulses", 32'(wrap_seen - w0), 32'd300);
        check("sat_wraps", 32'(WRAPS), 32'd255);
        check("sat_err", 32'(ERR), 32'd0);

        // Reset together with CLR while an acceptance is one edge away.
        s0 = step_seen;
        set_raw(3'b110);
        repeat (3) tick();
        not_RST = 1'b0;
        CLR     = 1'b1;
        tick();
        not_RST = 1'b1;
        CLR     = 1'b0;
        check_reset_outputs("rst_clr");
        check("rst_clr_no_step", 32'(step_seen - s0), 32'd0);
        repeat (3) tick();
        check("rst_refill_early", 32'(VALID), 32'd0);
        tick();
        check("rst_refill_count", 32'(COUNT), 32'd6);
        check("rst_refill_valid", 32'(VALID), 32'd1);
        check("rst_refill_step",  32'(STEP),  32'd0);
        repeat (2) tick();

        check("total_steps", 32'(step_seen), 32'd2415);
        check("total_wraps", 32'(wrap_seen), 32'd302);
        check("wrap_without_step", 32'(bad_wrap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
